// File: rtl/uart_rx_packet_ctrl_pkg.sv
// Shared types and constants for the UART packet framer: FSM states, byte type,
// default sync marker and bit positions inside the error/event pulse vector.
package uart_rx_packet_ctrl_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_HOLD
    } pkt_state_t;

    localparam byte_t DEFAULT_SYNC_BYTE = 8'hA5;

    localparam int ERR_CHK     = 0;
    localparam int ERR_LEN     = 1;
    localparam int ERR_TIMEOUT = 2;
    localparam int ERR_OVERRUN = 3;
    localparam int ERR_W       = 4;

endpackage

// File: rtl/uart_rx_packet_ctrl_buffer.sv
// Payload store: DEPTH x 8 register file, one write port, one registered read port.
// The array itself is never reset so a held packet survives only its own lifetime.
module uart_rx_packet_ctrl_buffer
    import uart_rx_packet_ctrl_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          i_Clock,
    input  logic          i_Rst_L,
    input  logic          i_Wr_En,
    input  logic [AW-1:0] i_Wr_Addr,
    input  byte_t         i_Wr_Data,
    input  logic [AW-1:0] i_Rd_Addr,
    output byte_t         o_Rd_Data
);

    byte_t r_mem [DEPTH];
    byte_t r_rd_data;

    always_ff @(posedge i_Clock) begin
        if (i_Wr_En) begin
            r_mem[i_Wr_Addr] <= i_Wr_Data;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[i_Rd_Addr];
        end
    end

    assign o_Rd_Data = r_rd_data;

endmodule

// File: rtl/uart_rx_packet_ctrl.sv
// Frames the UART RX byte stream (SYNC, LEN, payload, CHK) into checked packets held
// for a valid/ready consumer; reports checksum, length, timeout and overrun events.
//
//  state      | meaning
//  -----------+-----------------------------------------------
//  ST_IDLE    | hunting for SYNC_BYTE, other bytes ignored
//  ST_LEN     | next byte is the payload length
//  ST_PAYLOAD | storing payload bytes into the buffer
//  ST_CHK     | next byte is the XOR checksum
//  ST_HOLD    | good packet presented, waiting for Ready
module uart_rx_packet_ctrl
    import uart_rx_packet_ctrl_pkg::*;
#(
    parameter  int    CLKS_PER_BIT  = 217,
    parameter  int    MAX_PAYLOAD   = 16,
    parameter  byte_t SYNC_BYTE     = DEFAULT_SYNC_BYTE,
    parameter  int    TIMEOUT_BYTES = 4,
    localparam int    LW            = $clog2(MAX_PAYLOAD + 1),
    localparam int    AW            = $clog2(MAX_PAYLOAD)
) (
    input  logic          i_Clock,
    input  logic          i_Rst_L,
    input  logic          i_RX_DV,
    input  byte_t         i_RX_Byte,
    output logic          o_Pkt_Valid,
    input  logic          i_Pkt_Ready,
    output logic [LW-1:0] o_Pkt_Len,
    input  logic [AW-1:0] i_Rd_Addr,
    output byte_t         o_Rd_Data,
    output logic          o_Err_Chk,
    output logic          o_Err_Len,
    output logic          o_Err_Timeout,
    output logic          o_Overrun,
    output logic          o_Busy
);

    localparam int          TIMEOUT_CLKS = TIMEOUT_BYTES * 10 * CLKS_PER_BIT;
    localparam int          TW           = $clog2(TIMEOUT_CLKS);
    localparam logic [TW-1:0] TMO_LOAD   = TW'(TIMEOUT_CLKS - 1);

    pkt_state_t       r_state;
    logic [LW-1:0]    r_len;
    logic [AW-1:0]    r_idx;
    byte_t            r_xor;
    logic [TW-1:0]    r_tmo;
    logic             r_valid;
    logic [ERR_W-1:0] r_err;

    logic w_wr_en;
    logic w_last_byte;

    assign w_wr_en     = (r_state == ST_PAYLOAD) && i_RX_DV;
    assign w_last_byte = (LW'(r_idx) + LW'(1)) == r_len;

    // Gap timer counts down from TIMEOUT_CLKS-1; expiry is the cycle it sits at zero.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state <= ST_IDLE;
            r_len   <= '0;
            r_idx   <= '0;
            r_xor   <= '0;
            r_tmo   <= TMO_LOAD;
            r_valid <= 1'b0;
            r_err   <= '0;
        end else begin
            r_err <= '0;
            case (r_state)
                ST_IDLE: begin
                    r_tmo <= TMO_LOAD;
                    if (i_RX_DV && (i_RX_Byte == SYNC_BYTE)) begin
                        r_state <= ST_LEN;
                    end
                end
                ST_LEN, ST_PAYLOAD, ST_CHK: begin
                    if (i_RX_DV) begin
                        r_tmo <= TMO_LOAD;
                        if (r_state == ST_LEN) begin
                            r_xor <= i_RX_Byte;
                            r_idx <= '0;
                            if (i_RX_Byte > 8'(MAX_PAYLOAD)) begin
                                r_err[ERR_LEN] <= 1'b1;
                                r_state        <= ST_IDLE;
                            end else begin
                                r_len   <= i_RX_Byte[LW-1:0];
                                r_state <= (i_RX_Byte == 8'd0) ? ST_CHK : ST_PAYLOAD;
                            end
                        end else if (r_state == ST_PAYLOAD) begin
                            r_xor <= r_xor ^ i_RX_Byte;
                            r_idx <= r_idx + AW'(1);
                            if (w_last_byte) begin
                                r_state <= ST_CHK;
                            end
                        end else if (i_RX_Byte == r_xor) begin
                            r_valid <= 1'b1;
                            r_state <= ST_HOLD;
                        end else begin
                            r_err[ERR_CHK] <= 1'b1;
                            r_state        <= ST_IDLE;
                        end
                    end else if (r_tmo == '0) begin
                        r_err[ERR_TIMEOUT] <= 1'b1;
                        r_state            <= ST_IDLE;
                    end else begin
                        r_tmo <= r_tmo - TW'(1);
                    end
                end
                ST_HOLD: begin
                    r_tmo <= TMO_LOAD;
                    if (i_RX_DV) begin
                        r_err[ERR_OVERRUN] <= 1'b1;
                    end
                    if (r_valid && i_Pkt_Ready) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    uart_rx_packet_ctrl_buffer #(
        .DEPTH (MAX_PAYLOAD)
    ) u_buffer (
        .i_Clock   (i_Clock),
        .i_Rst_L   (i_Rst_L),
        .i_Wr_En   (w_wr_en),
        .i_Wr_Addr (r_idx),
        .i_Wr_Data (i_RX_Byte),
        .i_Rd_Addr (i_Rd_Addr),
        .o_Rd_Data (o_Rd_Data)
    );

    assign o_Pkt_Valid   = r_valid;
    assign o_Pkt_Len     = r_len;
    assign o_Err_Chk     = r_err[ERR_CHK];
    assign o_Err_Len     = r_err[ERR_LEN];
    assign o_Err_Timeout = r_err[ERR_TIMEOUT];
    assign o_Overrun     = r_err[ERR_OVERRUN];
    assign o_Busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// Bench for uart_rx_packet_ctrl: directed frames plus randomized frames judged by a
// frame-level model (checksum and length rules applied to whole frames).
module tb_uart_rx_packet_ctrl;

    localparam int CPB  = 4;
    localparam int MAXP = 16;
    localparam int TC   = 4 * 10 * CPB;
    localparam int LW   = $clog2(MAXP + 1);
    localparam int AW   = $clog2(MAXP);

    logic          clk;
    logic          rst_n;
    logic          dv;
    logic [7:0]    rx_byte;
    logic          pkt_valid;
    logic          pkt_ready;
    logic [LW-1:0] pkt_len;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          err_chk, err_len, err_to, overrun, busy;

    int n_checks = 0;
    int n_errors = 0;
    int cnt_chk = 0, cnt_len = 0, cnt_to = 0, cnt_ov = 0;
    int exp_chk = 0, exp_len = 0, exp_to = 0, exp_ov = 0;
    logic [7:0] pl[$];

    uart_rx_packet_ctrl #(
        .CLKS_PER_BIT  (CPB),
        .MAX_PAYLOAD   (MAXP),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_BYTES (4)
    ) dut (
        .i_Clock       (clk),
        .i_Rst_L       (rst_n),
        .i_RX_DV       (dv),
        .i_RX_Byte     (rx_byte),
        .o_Pkt_Valid   (pkt_valid),
        .i_Pkt_Ready   (pkt_ready),
        .o_Pkt_Len     (pkt_len),
        .i_Rd_Addr     (rd_addr),
        .o_Rd_Data     (rd_data),
        .o_Err_Chk     (err_chk),
        .o_Err_Len     (err_len),
        .o_Err_Timeout (err_to),
        .o_Overrun     (overrun),
        .o_Busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        cnt_chk <= cnt_chk + int'(err_chk);
        cnt_len <= cnt_len + int'(err_len);
        cnt_to  <= cnt_to + int'(err_to);
        cnt_ov  <= cnt_ov + int'(overrun);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        dv = 1'b1;
        rx_byte = b;
        @(negedge clk);
        dv = 1'b0;
    endtask

    task automatic check_held(input string tag, input int len);
        chk({tag, " valid"}, 32'(pkt_valid), 32'd1);
        chk({tag, " len"}, 32'(pkt_len), 32'(len));
        chk({tag, " busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < len; i++) begin
            rd_addr = AW'(i);
            tick(1);
            chk($sformatf("%s rd[%0d]", tag, i), 32'(rd_data), 32'(pl[i]));
        end
    endtask

    task automatic release_pkt(input string tag);
        pkt_ready = 1'b1;
        tick(1);
        pkt_ready = 1'b0;
        chk({tag, " valid after ready"}, 32'(pkt_valid), 32'd0);
        chk({tag, " busy after ready"}, 32'(busy), 32'd0);
    endtask

    // Frame-level model: good iff LEN fits and CHK equals XOR of LEN and payload.
    task automatic run_frame(input string tag, input logic [7:0] len, input bit corrupt,
                             input bit do_release);
        logic [7:0] x;
        logic [7:0] c;
        send(8'hA5);
        tick($urandom_range(0, 3));
        send(len);
        if (len > 8'(MAXP)) begin
            exp_len++;
            chk({tag, " err_len pulse"}, 32'(err_len), 32'd1);
            chk({tag, " busy after len err"}, 32'(busy), 32'd0);
            return;
        end
        x = len;
        for (int i = 0; i < int'(len); i++) begin
            tick($urandom_range(0, 3));
            send(pl[i]);
            x = x ^ pl[i];
        end
        tick($urandom_range(0, 3));
        chk({tag, " no early valid"}, 32'(pkt_valid), 32'd0);
        c = corrupt ? (x ^ 8'(($urandom_range(1, 255)))) : x;
        send(c);
        if (corrupt) begin
            exp_chk++;
            chk({tag, " err_chk pulse"}, 32'(err_chk), 32'd1);
            chk({tag, " no valid"}, 32'(pkt_valid), 32'd0);
            chk({tag, " busy after chk err"}, 32'(busy), 32'd0);
        end else begin
            chk({tag, " err_chk quiet"}, 32'(err_chk), 32'd0);
            check_held(tag, int'(len));
            if (do_release) release_pkt(tag);
        end
    endtask

    task automatic check_counts(input string tag);
        chk({tag, " chk count"}, 32'(cnt_chk), 32'(exp_chk));
        chk({tag, " len count"}, 32'(cnt_len), 32'(exp_len));
        chk({tag, " timeout count"}, 32'(cnt_to), 32'(exp_to));
        chk({tag, " overrun count"}, 32'(cnt_ov), 32'(exp_ov));
    endtask

    initial begin
        logic [7:0] len;
        logic [7:0] g;
        rst_n = 1'b0;
        dv = 1'b0;
        rx_byte = 8'h00;
        pkt_ready = 1'b0;
        rd_addr = '0;
        tick(3);
        chk("reset valid", 32'(pkt_valid), 32'd0);
        chk("reset len", 32'(pkt_len), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset rd_data", 32'(rd_data), 32'd0);
        chk("reset errs", 32'({err_chk, err_len, err_to, overrun}), 32'd0);
        rst_n = 1'b1;
        tick(2);

        pl = '{8'h11, 8'h22, 8'h33};
        run_frame("frame3", 8'd3, 1'b0, 1'b1);

        pl = '{8'h10, 8'h20};
        run_frame("badchk", 8'd2, 1'b1, 1'b1);
        pl.delete();
        run_frame("len0", 8'd0, 1'b0, 1'b1);

        run_frame("len17", 8'h11, 1'b0, 1'b1);
        send(8'h5A);
        chk("garbage ignored", 32'(busy), 32'd0);
        pl = '{8'h7E};
        run_frame("len1", 8'd1, 1'b0, 1'b1);

        pl = '{8'h10, 8'h20};
        for (int i = 0; i < MAXP; i++) if (i >= 2) pl.push_back(8'(i * 7));
        run_frame("lenmax", 8'(MAXP), 1'b0, 1'b1);

        // Timeout: counter expires TC cycles after the last DV
        send(8'hA5);
        send(8'h02);
        send(8'h10);
        tick(TC - 1);
        chk("timeout not yet", 32'(err_to), 32'd0);
        chk("timeout busy before", 32'(busy), 32'd1);
        tick(1);
        exp_to++;
        chk("timeout pulse", 32'(err_to), 32'd1);
        chk("timeout busy after", 32'(busy), 32'd0);

        send(8'hA5);
        send(8'h02);
        send(8'h10);
        tick(TC - 1);
        send(8'h20);
        chk("dv at expiry no timeout", 32'(err_to), 32'd0);
        chk("dv at expiry busy", 32'(busy), 32'd1);
        send(8'h32);
        pl = '{8'h10, 8'h20};
        check_held("expiry frame", 2);
        release_pkt("expiry frame");

        // Overrun while held, including the Valid&Ready cycle
        pl = '{8'h42, 8'h43};
        run_frame("hold", 8'd2, 1'b0, 1'b0);
        send(8'hA5);
        exp_ov++;
        chk("overrun pulse", 32'(overrun), 32'd1);
        check_held("after overrun", 2);
        dv = 1'b1;
        rx_byte = 8'hA5;
        pkt_ready = 1'b1;
        tick(1);
        dv = 1'b0;
        pkt_ready = 1'b0;
        exp_ov++;
        chk("overrun in ready cycle", 32'(overrun), 32'd1);
        chk("released valid", 32'(pkt_valid), 32'd0);
        send(8'h03);
        chk("no sync from dropped byte", 32'(busy), 32'd0);

        // Reset mid-payload
        send(8'hA5);
        send(8'h05);
        send(8'h11);
        send(8'h22);
        rst_n = 1'b0;
        #1;
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset valid", 32'(pkt_valid), 32'd0);
        chk("midreset len", 32'(pkt_len), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        pl = '{8'h01, 8'h02, 8'h04};
        run_frame("post reset", 8'd3, 1'b0, 1'b1);
        check_counts("directed");

        for (int f = 0; f < 30; f++) begin
            len = 8'($urandom_range(0, MAXP + 4));
            pl.delete();
            for (int i = 0; i < MAXP; i++) pl.push_back(8'($urandom));
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h00;
                send(g);
            end
            run_frame($sformatf("rand%0d", f), len, ($urandom_range(0, 3) == 0), 1'b1);
            tick($urandom_range(0, 3));
        end
        tick(2);
        check_counts("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
